// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, LSB first,
// one bit per clock, with borrow-out and a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             br;

  logic             d;
  logic             br_nx;
  logic [WIDTH-1:0] res_nx;
  logic             last;

  always_comb begin
    d      = a_r[0] ^ b_r[0] ^ br;
    br_nx  = (~a_r[0] & b_r[0]) |
             (~(a_r[0] ^ b_r[0]) & br);
    res_nx = {d, res[WIDTH-1:1]};
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            br    <= Bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_r <= a_r >> 1;
          b_r <= b_r >> 1;
          res <= res_nx;
          br  <= br_nx;
          cnt <= cnt + 1'b1;
          // final bit: publish result straight from the next-state values
          if (last) begin
            Diff  <= res_nx;
            Bout  <= br_nx;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): driver pushes
// expected results, a negedge monitor pops them on each done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;

  exp_t         q[$];
  int           done_cyc[$];
  int           cyc;
  int           passed;
  int           total;
  logic [W-1:0] last_d;
  logic         last_b;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, expv);
  endtask

  // Monitor: pop on done, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        exp_t e;
        done_cyc.push_back(cyc);
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_done: Diff=%b Bout=%b, no result expected",
                   Diff, Bout);
        end else begin
          e = q.pop_front();
          if (Diff == e.d && Bout == e.b) passed++;
          else $display("FAIL result: got Diff=%b Bout=%b expected Diff=%b Bout=%b",
                        Diff, Bout, e.d, e.b);
          last_d = e.d;
          last_b = e.b;
        end
      end else if (busy) begin
        total++;
        if (Diff == last_d && Bout == last_b) passed++;
        else $display("FAIL hold: got Diff=%b Bout=%b expected Diff=%b Bout=%b",
                      Diff, Bout, last_d, last_b);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic [W-1:0] ed,
                       input logic eb, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    Bin = bi;
    start = 1'b1;
    e.d = ed;
    e.b = eb;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    Bin = ~bi;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL timeout: busy still %b after 40 cycles", busy);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int bi);
    exp_t e;
    int r;
    r = a - b - bi;
    e.d = W'(r & ((1 << W) - 1));
    e.b = (a < b + bi);
    return e;
  endfunction

  initial begin
    exp_t e;
    int n0;
    passed = 0;
    total = 0;
    last_d = '0;
    last_b = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;

    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(Diff), 0);
    chk("rst_bout", int'(Bout), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 3 - 0 with cycle-exact busy/done timing
    issue(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1);
    chk("t0_busy", int'(busy), 1);
    chk("t0_done", int'(done), 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_busy", k), int'(busy), (k <= 4) ? 1 : 0);
      chk($sformatf("t%0d_done", k), int'(done), (k == 4) ? 1 : 0);
    end

    // borrow corner cases
    issue(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b1);
    wait_idle();
    issue(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b1);
    wait_idle();
    issue(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b1);
    wait_idle();

    // start pulsed and operands changed during SHIFT are ignored
    n0 = done_cyc.size();
    issue(4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    A = 4'b0000;
    B = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("one_done", done_cyc.size() - n0, 1);

    // start held high: three back-to-back operations
    n0 = done_cyc.size();
    @(posedge clk);
    #1;
    A = 4'b1001; B = 4'b0100; Bin = 1'b0; start = 1'b1;
    e.d = 4'b0101; e.b = 1'b0; q.push_back(e);
    e.d = 4'b1101; e.b = 1'b1; q.push_back(e);
    e.d = 4'b1101; e.b = 1'b0; q.push_back(e);
    @(posedge clk);
    #1;
    A = 4'b0010; B = 4'b0100; Bin = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    A = 4'b1111; B = 4'b0001; Bin = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    chk("tp_count", done_cyc.size() - n0, 3);
    if (done_cyc.size() - n0 == 3) begin
      chk("tp_gap1", done_cyc[n0+1] - done_cyc[n0], 6);
      chk("tp_gap2", done_cyc[n0+2] - done_cyc[n0+1], 6);
    end

    // asynchronous reset in the 2nd SHIFT cycle aborts the operation
    n0 = done_cyc.size();
    issue(4'b1100, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    last_d = '0;
    last_b = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(Diff), 0);
    chk("abort_bout", int'(Bout), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("abort_nodone", done_cyc.size() - n0, 0);
    issue(4'b0111, 4'b0010, 1'b1, 4'b0100, 1'b0, 1'b1);
    wait_idle();

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++) begin
          e = model(a, b, bi);
          issue(W'(a), W'(b), 1'(bi), e.d, e.b, 1'b1);
          wait_idle();
        end

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2..16.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-004 The port start SHALL be an input, 1 bit wide, and is the request to begin a subtraction.
REQ-005 The port A SHALL be an input, WIDTH bits wide, and is the minuend (unsigned).
REQ-006 The port B SHALL be an input, WIDTH bits wide, and is the subtrahend (unsigned).
REQ-007 The port Bin SHALL be an input, 1 bit wide, and is the borrow-in.
REQ-008 The port busy SHALL be an output, 1 bit wide, and is high while an operation is in progress or completing.
REQ-009 The port done SHALL be an output, 1 bit wide, and is a one-cycle pulse that marks Diff and Bout as newly valid.
REQ-010 The port Diff SHALL be an output, WIDTH bits wide, and is the difference result.
REQ-011 The port Bout SHALL be an output, 1 bit wide, and is the borrow-out result.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, using a bit counter of width ceil(log2(WIDTH+1)).
REQ-013 In IDLE, a rising clk edge with start=1 SHALL capture A, B and Bin into internal registers, clear the counter, and move the FSM to SHIFT.
REQ-014 Each clk edge in SHIFT SHALL process exactly one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 In SHIFT, the operand registers SHALL shift right by one bit per edge, and d SHALL shift into the MSB of an internal result register.
REQ-016 On the edge that processes the final (WIDTH-th) bit, the block SHALL load Diff from the completed result register and Bout from br_next, and the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-018 Latency SHALL be: capture edge N, result registered at edge N+WIDTH, done high in the cycle between edges N+WIDTH and N+WIDTH+1.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; both busy and done SHALL be driven from registered state only.
REQ-020 start SHALL be ignored whenever the FSM is in SHIFT or DONE; changes on A, B or Bin after the capture edge SHALL NOT affect the result.
REQ-021 If start is held high continuously, a new operation SHALL be captured at the first IDLE edge after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-022 Diff and Bout SHALL hold the last completed result, unchanged, until the next completion; they SHALL NOT change during SHIFT.
REQ-023 Results SHALL satisfy Diff = (A - B - Bin) mod 2^WIDTH, and Bout = 1 iff A < B + Bin (unsigned compare, done at WIDTH+1 bits).

Reset
REQ-024 While rst_n=0, the FSM SHALL be forced to IDLE immediately, regardless of clk, and the counter and all internal registers SHALL be 0.
REQ-025 While rst_n=0, the outputs SHALL be busy=0, done=0, Diff=0 and Bout=0.
REQ-026 Reset asserted mid-operation SHALL abort it: no done pulse, and Diff and Bout read 0.
REQ-027 After rst_n deasserts, the first rising clk edge with start=1 SHALL be accepted as a capture edge.

Verification (WIDTH=4)
REQ-028 A=0101, B=0011, Bin=0, start pulsed at edge N -> Diff=0010, Bout=0, done high for one cycle after edge N+4; busy high from edge N to edge N+5.
REQ-029 A=0000, B=0001, Bin=0 -> Diff=1111, Bout=1; then A=0000, B=0000, Bin=1 -> Diff=1111, Bout=1; then A=1111, B=1111, Bin=1 -> Diff=1111, Bout=1.
REQ-030 Start A=1011, B=0011, Bin=0, then change A/B to 0000/0001 and pulse start during SHIFT -> Diff=1000, Bout=0, exactly one done pulse.
REQ-031 start held high for 3 operations -> exactly three done pulses spaced 6 cycles apart, each result correct; Diff stays stable between pulses.
REQ-032 rst_n driven low asynchronously during the 2nd SHIFT cycle -> busy, done, Diff and Bout go to 0 immediately with no done pulse; a subsequent 0111 - 0010 - 1 yields Diff=0100, Bout=0.
REQ-033 Exhaustive test over all 512 combinations of (A, B, Bin) -> Diff and Bout match the REQ-023 formulas at every done pulse, with no mismatches.
